// File: rtl/boxhead_gfx_pkg.sv
// Shared graphics definitions: screen geometry, draw command record and sequencer states.
// Used by sprite_draw_sequencer (optional statistics via SPRITE_SEQ_STATS_EN) and draw_cmd_fifo.
package boxhead_gfx_pkg;

    localparam logic [9:0]  SCREEN_W          = 10'd640;
    localparam logic [9:0]  SCREEN_H          = 10'd480;
    localparam logic [15:0] TRANSPARENT_COLOR = 16'h07E0;
    localparam int unsigned GFX_SRC_ADDR_W    = 19;

    typedef struct packed {
        logic [9:0]                x;
        logic [9:0]                y;
        logic [9:0]                w;
        logic [9:0]                h;
        logic [GFX_SRC_ADDR_W-1:0] src_addr;
        logic                      flip_x;
    } draw_cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_ISSUE,
        S_RELEASE
    } seq_state_e;

    // A command the copy engine must never see: degenerate, wrapping, or fully off-screen.
    function automatic logic cmd_rejected(input draw_cmd_t cmd,
                                          input logic [10:0] x_end,
                                          input logic [10:0] y_end);
        return (cmd.w == '0) || (cmd.h == '0) || x_end[10] || y_end[10] ||
               (cmd.x >= SCREEN_W) || (cmd.y >= SCREEN_H);
    endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Synchronous FIFO of draw commands; flush empties it and wins over a same-cycle push.
module draw_cmd_fifo
    import boxhead_gfx_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  draw_cmd_t              push_data,
    input  logic                   pop,
    input  logic                   flush,
    output draw_cmd_t              pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned AW = $clog2(Depth);

    draw_cmd_t     mem_q [Depth];
    draw_cmd_t     mem_d [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == (AW+1)'(Depth));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Queues sprite draw commands, validates them and runs the copy engine execute/done handshake.
// Define SPRITE_SEQ_STATS_EN to build the drawn/dropped statistics counters.
module sprite_draw_sequencer
    import boxhead_gfx_pkg::*;
#(
    parameter int unsigned SrcAddrWidth = 19,
    parameter int unsigned QueueDepth   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [9:0]                   cmd_x,
    input  logic [9:0]                   cmd_y,
    input  logic [9:0]                   cmd_w,
    input  logic [9:0]                   cmd_h,
    input  logic [SrcAddrWidth-1:0]      cmd_src_addr,
    input  logic                         cmd_flip_x,
    input  logic                         enable,
    input  logic                         abort,
    output logic                         idle,
    output logic [$clog2(QueueDepth):0]  queue_count,
    output logic [9:0]                   dest_x_start,
    output logic [9:0]                   dest_x_end,
    output logic [9:0]                   dest_y_start,
    output logic [9:0]                   dest_y_end,
    output logic [SrcAddrWidth-1:0]      src_addr_start,
    output logic                         flip_x,
    output logic                         execute,
    input  logic                         done,
    output logic [15:0]                  drawn_count,
    output logic [15:0]                  dropped_count
);

    seq_state_e state_q, state_d;

    draw_cmd_t cmd_in, fifo_head;
    logic      fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic      load_out, cmd_bad;

    draw_cmd_t               work_q, work_d;
    logic [10:0]             x_end_q, x_end_d;
    logic [10:0]             y_end_q, y_end_d;
    logic [9:0]              dest_x_start_q, dest_x_start_d;
    logic [9:0]              dest_x_end_q, dest_x_end_d;
    logic [9:0]              dest_y_start_q, dest_y_start_d;
    logic [9:0]              dest_y_end_q, dest_y_end_d;
    logic [SrcAddrWidth-1:0] src_addr_q, src_addr_d;
    logic                    flip_x_q, flip_x_d;

    always_comb begin
        cmd_in.x        = cmd_x;
        cmd_in.y        = cmd_y;
        cmd_in.w        = cmd_w;
        cmd_in.h        = cmd_h;
        cmd_in.src_addr = GFX_SRC_ADDR_W'(cmd_src_addr);
        cmd_in.flip_x   = cmd_flip_x;
    end

    assign cmd_ready = !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready && !abort;

    draw_cmd_fifo #(
        .Depth(QueueDepth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(cmd_in),
        .pop      (fifo_pop),
        .flush    (abort),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (queue_count)
    );

    assign cmd_bad = cmd_rejected(work_q, x_end_q, y_end_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (!fifo_empty && enable) state_d = S_FETCH;
                S_FETCH:   state_d = S_CHECK;
                S_CHECK:   state_d = cmd_bad ? S_IDLE : S_ISSUE;
                S_ISSUE:   if (done) state_d = S_RELEASE;
                S_RELEASE: state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        execute  = (state_q == S_ISSUE);
        fifo_pop = (state_q == S_FETCH);
        load_out = (state_q == S_CHECK) && !cmd_bad && !abort;
        idle     = fifo_empty && (state_q == S_IDLE) && !execute;
    end

    always_comb begin
        work_d         = work_q;
        x_end_d        = x_end_q;
        y_end_d        = y_end_q;
        dest_x_start_d = dest_x_start_q;
        dest_x_end_d   = dest_x_end_q;
        dest_y_start_d = dest_y_start_q;
        dest_y_end_d   = dest_y_end_q;
        src_addr_d     = src_addr_q;
        flip_x_d       = flip_x_q;
        if (fifo_pop) begin
            work_d  = fifo_head;
            x_end_d = {1'b0, fifo_head.x} + {1'b0, fifo_head.w};
            y_end_d = {1'b0, fifo_head.y} + {1'b0, fifo_head.h};
        end
        // Engine-facing registers change only on entry to ISSUE, so they stay frozen while execute=1.
        if (load_out) begin
            dest_x_start_d = work_q.x;
            dest_x_end_d   = x_end_q[9:0];
            dest_y_start_d = work_q.y;
            dest_y_end_d   = y_end_q[9:0];
            src_addr_d     = SrcAddrWidth'(work_q.src_addr);
            flip_x_d       = work_q.flip_x;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q         <= '0;
            x_end_q        <= '0;
            y_end_q        <= '0;
            dest_x_start_q <= '0;
            dest_x_end_q   <= '0;
            dest_y_start_q <= '0;
            dest_y_end_q   <= '0;
            src_addr_q     <= '0;
            flip_x_q       <= 1'b0;
        end else begin
            work_q         <= work_d;
            x_end_q        <= x_end_d;
            y_end_q        <= y_end_d;
            dest_x_start_q <= dest_x_start_d;
            dest_x_end_q   <= dest_x_end_d;
            dest_y_start_q <= dest_y_start_d;
            dest_y_end_q   <= dest_y_end_d;
            src_addr_q     <= src_addr_d;
            flip_x_q       <= flip_x_d;
        end
    end

    assign dest_x_start   = dest_x_start_q;
    assign dest_x_end     = dest_x_end_q;
    assign dest_y_start   = dest_y_start_q;
    assign dest_y_end     = dest_y_end_q;
    assign src_addr_start = src_addr_q;
    assign flip_x         = flip_x_q;

`ifdef SPRITE_SEQ_STATS_EN
    logic [15:0] drawn_q, drawn_d;
    logic [15:0] dropped_q, dropped_d;

    // An aborted sprite is neither drawn nor dropped.
    always_comb begin
        drawn_d   = drawn_q + 16'((state_q == S_ISSUE) && done && !abort);
        dropped_d = dropped_q + 16'((state_q == S_CHECK) && cmd_bad && !abort);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drawn_q   <= '0;
            dropped_q <= '0;
        end else begin
            drawn_q   <= drawn_d;
            dropped_q <= dropped_d;
        end
    end

    assign drawn_count   = drawn_q;
    assign dropped_count = dropped_q;
`else
    assign drawn_count   = '0;
    assign dropped_count = '0;
`endif

endmodule
